// File: rtl/vga_pkg.sv
// Shared 1024x768@60 Hz raster constants, colour width and the sync bundle
// carried through the renderer-latency delay line.
`timescale 1ns/1ps
package vga_pkg;
  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int COLOR_W  = 12;

  // Screen centre used by the grid/ball/plate renderers.
  localparam int CENTER_X = 511;
  localparam int CENTER_Y = 383;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Syncs deasserted (active-low pins high) and blanked.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};
endpackage

// File: rtl/vga_sync_delay.sv
// Shift register that delays {hs, vs, blank} by DEPTH enabled cycles so the
// syncs line up with the renderer output; DEPTH=0 degenerates to a wire.
`timescale 1ns/1ps
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] d,
  output logic [2:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_shift
    logic [2:0] stage [DEPTH];

    // Reset fills the line with idle syncs so the pins stay blank until real
    // positions have propagated through.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus delayed sync/blank and the registered VGA pin stage;
// counter position reaches the pins PIPE_DELAY+1 enabled cycles later.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PIPE_DELAY = 1
) (
  input  logic                         clk_65mhz,
  input  logic                         rst_n,
  input  logic                         pix_en,
  output logic [vga_pkg::HCOUNT_W-1:0] hcount,
  output logic [vga_pkg::VCOUNT_W-1:0] vcount,
  output logic                         blank,
  output logic                         frame_start,
  input  logic [vga_pkg::COLOR_W-1:0]  pixel_in,
  output logic [vga_pkg::COLOR_W-1:0]  vga_rgb,
  output logic                         vga_hs,
  output logic                         vga_vs
);
  import vga_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] HS_FIRST = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_LAST  = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(V_ACTIVE);
  localparam logic [VCOUNT_W-1:0] VS_FIRST = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_LAST  = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  sync_t raw_sync;
  sync_t dly_sync;

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // vsync is decoded from vcount alone, so it toggles at hcount=0 of its lines.
  always_comb begin
    raw_sync.blank = (hcount >= H_ACT) || (vcount >= V_ACT);
    raw_sync.hs    = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    raw_sync.vs    = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
  end

  assign blank       = raw_sync.blank;
  assign frame_start = (hcount == '0) && (vcount == '0);

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk   (clk_65mhz),
    .rst_n (rst_n),
    .en    (pix_en),
    .d     (raw_sync),
    .q     (dly_sync)
  );

  always_ff @(posedge clk_65mhz or negedge rst_n) begin
    if (!rst_n) begin
      vga_rgb <= '0;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_en) begin
      vga_rgb <= dly_sync.blank ? '0 : pixel_in;
      vga_hs  <= dly_sync.hs;
      vga_vs  <= dly_sync.vs;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size raster with PIPE_DELAY=1, plus two short-frame
// instances (PIPE_DELAY 0 and 4) sharing the same stimulus for frame/latency.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [11:0] pixel_in = 12'h000;

  always #5 clk = ~clk;

  logic [10:0] h1, h0, h4;
  logic [9:0]  v1, v0, v4;
  logic        b1, b0, b4, fs1, fs0, fs4, hs1, hs0, hs4, vs1, vs0, vs4;
  logic [11:0] rgb1, rgb0, rgb4;

  vga_timing_gen u_d1 (
    .clk_65mhz(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(h1), .vcount(v1),
    .blank(b1), .frame_start(fs1), .pixel_in(pixel_in), .vga_rgb(rgb1),
    .vga_hs(hs1), .vga_vs(vs1));

  // Short frames: 4 active + 1 FP + 6 sync + 1 BP = 12 lines of 1344 pixels.
  vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(6), .V_BP(1), .PIPE_DELAY(0)) u_d0 (
    .clk_65mhz(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(h0), .vcount(v0),
    .blank(b0), .frame_start(fs0), .pixel_in(pixel_in), .vga_rgb(rgb0),
    .vga_hs(hs0), .vga_vs(vs0));

  vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(6), .V_BP(1), .PIPE_DELAY(4)) u_d4 (
    .clk_65mhz(clk), .rst_n(rst_n), .pix_en(pix_en), .hcount(h4), .vcount(v4),
    .blank(b4), .frame_start(fs4), .pixel_in(pixel_in), .vga_rgb(rgb4),
    .vga_hs(hs4), .vga_vs(vs4));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag, input logic [10:0] h, input logic [9:0] v,
                           input logic b, input logic fs, input logic [11:0] rgb,
                           input logic hs, input logic vs);
    check({tag, "_hcount"}, h, 0);
    check({tag, "_vcount"}, v, 0);
    check({tag, "_blank"}, b, 0);
    check({tag, "_frame_start"}, fs, 1);
    check({tag, "_rgb"}, rgb, 0);
    check({tag, "_hs"}, hs, 1);
    check({tag, "_vs"}, vs, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        en;
    logic [11:0] pix;
    int          h;
    logic        fs;
    logic [11:0] rgb1;
    logic [11:0] rgb0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, mism, cnt, lo, chg, lat1, lat0, lat4, vslo, hsfall;
    logic [40:0] snap;
    logic        prev_hs;
    logic [10:0] prev_h;
    logic [9:0]  prev_v;

    tbl[0] = '{1'b1, 12'h123, 1, 1'b0, 12'h000, 12'h123};
    tbl[1] = '{1'b1, 12'h456, 2, 1'b0, 12'h456, 12'h456};
    tbl[2] = '{1'b0, 12'h789, 2, 1'b0, 12'h456, 12'h456};
    tbl[3] = '{1'b1, 12'h789, 3, 1'b0, 12'h789, 12'h789};
    tbl[4] = '{1'b1, 12'hABC, 4, 1'b0, 12'hABC, 12'hABC};
    tbl[5] = '{1'b0, 12'hDEF, 4, 1'b0, 12'hABC, 12'hABC};
    tbl[6] = '{1'b1, 12'hDEF, 5, 1'b0, 12'hDEF, 12'hDEF};
    tbl[7] = '{1'b1, 12'h0F0, 6, 1'b0, 12'h0F0, 12'h0F0};

    repeat (3) @(negedge clk);
    check_rst("rst_d1", h1, v1, b1, fs1, rgb1, hs1, vs1);
    check_rst("rst_d0", h0, v0, b0, fs0, rgb0, hs0, vs0);
    check_rst("rst_d4", h4, v4, b4, fs4, rgb4, hs4, vs4);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pix_en   = tbl[i].en;
      pixel_in = tbl[i].pix;
      tick();
      check($sformatf("vec%0d_hcount", i), h1, tbl[i].h);
      check($sformatf("vec%0d_frame_start", i), fs1, tbl[i].fs);
      check($sformatf("vec%0d_rgb_d1", i), rgb1, tbl[i].rgb1);
      check($sformatf("vec%0d_rgb_d0", i), rgb0, tbl[i].rgb0);
    end

    // Line wrap
    pix_en = 1'b1;
    n = 0;
    while (h1 != 11'd1343 && n < 3000) begin tick(); n++; end
    check("wrap_pre_hcount", h1, 1343);
    check("wrap_pre_vcount", v1, 0);
    check("wrap_pre_blank", b1, 1);
    tick();
    check("wrap_hcount", h1, 0);
    check("wrap_vcount", v1, 1);
    check("wrap_blank", b1, 0);
    check("wrap_frame_start", fs1, 0);

    // hsync edge position and width on line 1
    n = 0;
    while (hs1 !== 1'b0 && n < 2000) begin tick(); n++; end
    check("hs_fall_offset", n, 1050);
    n = 0;
    while (hs1 === 1'b0 && n < 2000) begin tick(); n++; end
    check("hs_low_width", n, 136);
    n = 0;
    while (h1 != 11'd0 && n < 2000) begin tick(); n++; end
    check("line2_vcount", v1, 2);

    // Constant white: pins show position n-2 of this line
    pixel_in = 12'hFFF;
    mism = 0;
    cnt = 0;
    for (int k = 1; k <= 1344; k++) begin
      tick();
      if (rgb1 !== (((k >= 2) && (k - 2 < 1024)) ? 12'hFFF : 12'h000)) mism++;
      if (rgb1 === 12'hFFF) cnt++;
    end
    check("white_mismatches", mism, 0);
    check("white_pixel_count", cnt, 1024);
    check("white_end_vcount", v1, 3);

    // pix_en toggling: enabled on even clocks only
    lo = 0;
    chg = 0;
    for (int c = 0; c < 2688; c++) begin
      pix_en = (c % 2 == 0);
      snap = {h1, v1, rgb1, hs1, vs1, b1, fs1, 2'b00};
      tick();
      if (!pix_en && snap !== {h1, v1, rgb1, hs1, vs1, b1, fs1, 2'b00}) chg++;
      if (hs1 === 1'b0) lo++;
    end
    pix_en = 1'b1;
    check("toggle_hs_low_clocks", lo, 272);
    check("toggle_disabled_changes", chg, 0);
    check("toggle_end_hcount", h1, 0);
    check("toggle_end_vcount", v1, 4);

    // Mid-line reset
    n = 0;
    while (h1 != 11'd600 && n < 2000) begin tick(); n++; end
    check("pre_reset_rgb", rgb1, 12'hFFF);
    rst_n = 1'b0;
    #1;
    check_rst("midrst_d1", h1, v1, b1, fs1, rgb1, hs1, vs1);
    repeat (3) @(negedge clk);
    check("midrst_hold_hcount", h1, 0);
    rst_n = 1'b1;
    check("release_frame_start", fs1, 1);
    lat1 = 0; lat0 = 0; lat4 = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (lat1 == 0 && rgb1 === 12'hFFF) lat1 = t;
      if (lat0 == 0 && rgb0 === 12'hFFF) lat0 = t;
      if (lat4 == 0 && rgb4 === 12'hFFF) lat4 = t;
    end
    check("latency_pipe1", lat1, 2);
    check("latency_pipe0", lat0, 1);
    check("latency_pipe4", lat4, 5);
    check("restart_hcount", h1, 8);
    check("restart_frame_start", fs1, 0);

    // One short frame on the PIPE_DELAY=4 instance
    n = 0;
    while (fs4 !== 1'b1 && n < 20000) begin tick(); n++; end
    check("frame_found", fs4, 1);
    n = 0; vslo = 0; hsfall = 0;
    prev_hs = hs4; prev_h = h4; prev_v = v4;
    do begin
      prev_h = h4;
      prev_v = v4;
      tick();
      n++;
      if (vs4 === 1'b0) vslo++;
      if (prev_hs === 1'b1 && hs4 === 1'b0) hsfall++;
      prev_hs = hs4;
    end while (fs4 !== 1'b1 && n < 20000);
    check("frame_period", n, 16128);
    check("frame_vs_low", vslo, 8064);
    check("frame_hs_pulses", hsfall, 12);
    check("frame_last_hcount", prev_h, 1343);
    check("frame_last_vcount", prev_v, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
